// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: single-port unified memory arbiter between fetch and load/store ports.
// Define ARB_FAIRNESS_EN to force a fetch grant after STARVE_MAX consecutive data grants.
module mips32_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]        state;
    logic              owner_d, lat_we, drop;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, cap, if_hold, d_hold;
    logic [2:0]        cnt;
    logic [SW-1:0]     starve;
    logic              idle, force_if, grant_d, grant_if, resp;

    assign idle     = state == IDLE && !rst;
    assign force_if = if_req_valid && starve >= SW'(STARVE_MAX);
    assign grant_d  = idle && d_req_valid && !force_if;
    assign grant_if = idle && if_req_valid && (!d_req_valid || force_if);

    assign d_req_ready  = grant_d;
    assign if_req_ready = grant_if;
    assign busy         = state != IDLE;
    assign mem_en       = state == ACCESS;
    assign mem_we       = mem_en && lat_we;
    assign mem_addr     = lat_addr;
    assign mem_wdata    = lat_wdata;
    assign resp         = state == RESP;
    assign d_rsp_valid  = resp && owner_d;
    assign if_rsp_valid = resp && !owner_d && !drop && !if_flush;
    // Response data is only exposed on a pulse; otherwise the last delivered value is held.
    assign if_rsp_data  = if_rsp_valid ? cap : if_hold;
    assign d_rsp_data   = d_rsp_valid ? cap : d_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            cap       <= '0;
            drop      <= 1'b0;
            if_hold   <= '0;
            d_hold    <= '0;
        end else begin
            if (if_rsp_valid) if_hold <= cap;
            if (d_rsp_valid) d_hold <= cap;
            if (if_flush && state != IDLE && !owner_d) drop <= 1'b1;
            case (state)
                IDLE: if (grant_d || grant_if) begin
                    state     <= ACCESS;
                    owner_d   <= grant_d;
                    lat_we    <= grant_d && d_req_we;
                    lat_addr  <= grant_d ? d_req_addr : if_req_addr;
                    lat_wdata <= grant_d ? d_req_wdata : '0;
                end
                ACCESS: begin
                    cnt   <= 3'(MEM_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    cap   <= lat_we ? '0 : mem_rdata;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                default: begin
                    state <= IDLE;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_FAIRNESS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve <= '0;
        else if (!if_req_valid || grant_if) starve <= '0;
        else if (grant_d) starve <= starve + SW'(1);
    end
`else
    assign starve = '0;
`endif
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: scoreboard bench with a cycle-level transaction model of the arbiter.
// Compile with ARB_FAIRNESS_EN defined to expect the fairness behaviour.
module tb_mips32_mem_arbiter;
    localparam int LAT  = 3;
    localparam int SMAX = 4;
    localparam int P    = LAT + 3;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0, if_rsp_valid;
    logic [9:0]  if_req_addr = '0;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid;
    logic [9:0]  d_req_addr = '0;
    logic [31:0] d_req_wdata = '0, d_rsp_data;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] pipe [LAT];

    // Memory environment: read data appears LAT cycles after the mem_en cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            pipe[0] <= mem[mem_addr];
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct {
        bit          is_d;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] data;
        int          acc;
        bit          drop;
    } txn_t;

    txn_t sb[$];
    int total = 0, bad = 0, cyc = 0;
    int free_at = 0, starve = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: model of one-at-a-time arbitration; each accepted request occupies P cycles.
    always @(negedge clk) begin
        bit   idle, force_f, gd, gi, exp_en, due, exp_dv, exp_iv;
        txn_t t;
        if (rst) begin
            sb.delete();
            free_at = 0;
            starve  = 0;
            chk("rst_ctl", {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_en, mem_we, busy}, 0);
            chk("rst_rsp", {if_rsp_data, d_rsp_data}, 0);
            chk("rst_mem", {mem_addr, mem_wdata}, 0);
        end else begin
            idle    = cyc >= free_at;
            force_f = FAIR && if_req_valid && starve >= SMAX;
            gd      = idle && d_req_valid && !force_f;
            gi      = idle && if_req_valid && (!d_req_valid || force_f);
            chk("d_ready", d_req_ready, gd);
            chk("if_ready", if_req_ready, gi);
            chk("busy", busy, !idle);
            if (if_flush && sb.size() > 0 && !sb[0].is_d && cyc > sb[0].acc) sb[0].drop = 1'b1;
            exp_en = sb.size() > 0 && cyc == sb[0].acc + 1;
            chk("mem_en", mem_en, exp_en);
            if (exp_en) begin
                chk("mem_we", mem_we, sb[0].we);
                chk("mem_addr", mem_addr, sb[0].addr);
                if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
            end
            due    = sb.size() > 0 && cyc == sb[0].acc + LAT + 2;
            exp_dv = due && sb[0].is_d;
            exp_iv = due && !sb[0].is_d && !sb[0].drop;
            chk("d_rsp_valid", d_rsp_valid, exp_dv);
            chk("if_rsp_valid", if_rsp_valid, exp_iv);
            if (exp_dv) chk("d_rsp_data", d_rsp_data, sb[0].data);
            if (exp_iv) chk("if_rsp_data", if_rsp_data, sb[0].data);
            if (due) void'(sb.pop_front());
            if (gd || gi) begin
                t.is_d  = gd;
                t.we    = gd && d_req_we;
                t.addr  = gd ? d_req_addr : if_req_addr;
                t.wdata = d_req_wdata;
                t.data  = t.we ? 32'h0 : ref_mem[t.addr];
                t.acc   = cyc;
                t.drop  = 1'b0;
                if (t.we) ref_mem[t.addr] = t.wdata;
                sb.push_back(t);
                free_at = cyc + P;
            end
            if (!if_req_valid || gi) starve = 0;
            else if (gd) starve++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [9:0] a, input bit fl);
        bit ok = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = a;
        if_flush     = fl;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = if_req_ready;
            @(posedge clk);
            #1;
        end
        if_req_valid = 1'b0;
        if_flush     = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: got no ready want ready addr %h", a);
        end
    endtask

    task automatic do_d(input bit we, input logic [9:0] a, input logic [31:0] wd);
        bit ok = 1'b0;
        d_req_valid = 1'b1;
        d_req_we    = we;
        d_req_addr  = a;
        d_req_wdata = wd;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = d_req_ready;
            @(posedge clk);
            #1;
        end
        d_req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL data_timeout: got no ready want ready addr %h", a);
        end
    endtask

    initial begin
        int  ig;
        bit  dn, da, ia;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5]     = 32'h2140000A;
        ref_mem[5] = 32'h2140000A;
        step(2);
        rst = 1'b0;
        step(1);
        fetch(10'd5, 1'b0);
        step(P + 2);
        fork
            do_d(1'b0, 10'h10, 32'h0);
            fetch(10'h20, 1'b0);
        join
        step(P + 2);
        do_d(1'b1, 10'h3FF, 32'hDEADBEEF);
        step(P + 2);
        do_d(1'b0, 10'h3FF, 32'h0);
        step(P + 2);
        ig = 0;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 10'h1;
        if_req_valid = 1'b1;
        if_req_addr  = 10'h40;
        for (int k = 0; k < 5 * P; k++) begin
            @(negedge clk);
            ig += int'(if_req_ready);
            dn = d_req_ready;
            @(posedge clk);
            #1;
            if (dn) d_req_addr = 10'($urandom_range(0, 31));
        end
        d_req_valid  = 1'b0;
        if_req_valid = 1'b0;
        chk("starve_fetch_grants", ig, FAIR ? 1 : 0);
        step(P + 2);
        fetch(10'd7, 1'b0);
        step(1);
        if_flush = 1'b1;
        step(1);
        if_flush = 1'b0;
        step(P);
        fetch(10'd8, 1'b0);
        step(P + 2);
        fetch(10'd9, 1'b0);
        step(LAT + 1);
        if_flush = 1'b1;
        step(1);
        if_flush = 1'b0;
        step(2);
        fetch(10'd11, 1'b1);
        step(P + 2);
        do_d(1'b0, 10'h3, 32'h0);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        fetch(10'd5, 1'b0);
        step(P + 2);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            da = d_req_valid && d_req_ready;
            ia = if_req_valid && if_req_ready;
            @(posedge clk);
            #1;
            if (da || !d_req_valid) begin
                d_req_valid = $urandom_range(0, 2) == 0;
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_addr  = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
                d_req_wdata = $urandom;
            end
            if (ia || !if_req_valid) begin
                if_req_valid = 1'($urandom_range(0, 1));
                if_req_addr  = 10'($urandom_range(0, 31));
            end
            if_flush = $urandom_range(0, 9) == 0;
        end
        d_req_valid  = 1'b0;
        if_req_valid = 1'b0;
        if_flush     = 1'b0;
        step(P + 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
